// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator bridging a CPU request/response port to the mem_axi_* bus.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module axi_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_insn,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_axi_awvalid,
    input  logic                mem_axi_awready,
    output logic [ADDR_W-1:0]   mem_axi_awaddr,
    output logic [2:0]          mem_axi_awprot,
    output logic                mem_axi_wvalid,
    input  logic                mem_axi_wready,
    output logic [DATA_W-1:0]   mem_axi_wdata,
    output logic [DATA_W/8-1:0] mem_axi_wstrb,
    input  logic                mem_axi_bvalid,
    output logic                mem_axi_bready,
    output logic                mem_axi_arvalid,
    input  logic                mem_axi_arready,
    output logic [ADDR_W-1:0]   mem_axi_araddr,
    output logic [2:0]          mem_axi_arprot,
    input  logic                mem_axi_rvalid,
    output logic                mem_axi_rready,
    input  logic [DATA_W-1:0]   mem_axi_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW_W = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]          state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                insn_q;
    logic                aw_done;
    logic                w_done;
    logic                aw_hs;
    logic                w_hs;
    logic                timeout;

    assign req_ready      = (state == S_IDLE);
    assign mem_axi_awaddr = addr_q;
    assign mem_axi_araddr = addr_q;
    assign mem_axi_wdata  = wdata_q;
    assign mem_axi_wstrb  = wstrb_q;
    assign mem_axi_arprot = {insn_q, 2'b00};
    assign mem_axi_awprot = 3'b000;

    assign aw_hs = mem_axi_awvalid && mem_axi_awready;
    assign w_hs  = mem_axi_wvalid && mem_axi_wready;

    // NOTE: state registers use non-blocking assignments and reset asynchronously on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            insn_q          <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
        end else if (timeout) begin
            // Abandon the stalled transaction; the watchdog wins over a same-cycle handshake.
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            resp_rdata      <= '0;
            resp_valid      <= 1'b1;
            state           <= S_RESP;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        insn_q  <= req_insn;
                        if (req_we) begin
                            mem_axi_awvalid <= 1'b1;
                            mem_axi_wvalid  <= 1'b1;
                            aw_done         <= 1'b0;
                            w_done          <= 1'b0;
                            state           <= S_AW_W;
                        end else begin
                            mem_axi_arvalid <= 1'b1;
                            state           <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (mem_axi_arready) begin
                        mem_axi_arvalid <= 1'b0;
                        mem_axi_rready  <= 1'b1;
                        state           <= S_R;
                    end
                end
                S_R: begin
                    if (mem_axi_rvalid) begin
                        mem_axi_rready <= 1'b0;
                        resp_rdata     <= mem_axi_rdata;
                        resp_valid     <= 1'b1;
                        state          <= S_RESP;
                    end
                end
                S_AW_W: begin
                    // Address and data channels complete independently, in either order or together.
                    if (aw_hs) begin
                        mem_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_hs) begin
                        mem_axi_wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        mem_axi_bready <= 1'b1;
                        state          <= S_B;
                    end
                end
                S_B: begin
                    if (mem_axi_bvalid) begin
                        mem_axi_bready <= 1'b0;
                        resp_rdata     <= '0;
                        resp_valid     <= 1'b1;
                        state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wdog_cnt;
    logic        busy;

    assign busy    = (state == S_AR) || (state == S_R) || (state == S_AW_W) || (state == S_B);
    assign timeout = busy && (wdog_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            resp_err <= 1'b0;
        end else begin
            if (busy) wdog_cnt <= wdog_cnt + 32'd1;
            else      wdog_cnt <= '0;
            if (timeout)                          resp_err <= 1'b1;
            else if (state == S_RESP && resp_ready) resp_err <= 1'b0;
        end
    end
`else
    // Without the watchdog the limit has no effect and the master waits indefinitely.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: randomized-delay AXI-Lite responder, protocol monitor
// and a word-level memory reference model.
module tb_axi_lite_master;

    localparam int TO_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_insn;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_axi_awvalid, mem_axi_awready, mem_axi_wvalid, mem_axi_wready;
    logic        mem_axi_bvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_arready;
    logic        mem_axi_rvalid, mem_axi_rready;
    logic [31:0] mem_axi_awaddr, mem_axi_araddr, mem_axi_wdata, mem_axi_rdata;
    logic [3:0]  mem_axi_wstrb;
    logic [2:0]  mem_axi_awprot, mem_axi_arprot;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_insn(req_insn),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
        .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
        .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
        .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready), .mem_axi_rdata(mem_axi_rdata)
    );

    // Reference memory (updated from CPU requests) and responder memory (updated from AXI beats).
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] resp_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
        return init_word(a);
    endfunction

    function automatic logic [31:0] resp_read(input logic [31:0] a);
        if (resp_mem.exists(a >> 2)) return resp_mem[a >> 2];
        return init_word(a);
    endfunction

    // Responder configuration and captured beats.
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit          r_pend, b_pend, aw_got, w_got;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [2:0]  cap_arprot, cap_awprot;
    logic [3:0]  cap_wstrb;
    // Values present during the last posedge (both sides are stable from negedge to posedge).
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [2:0]  s_arprot, s_awprot;
    logic [3:0]  s_wstrb;

    initial begin : responder
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
        mem_axi_arready = 0; mem_axi_rvalid = 0; mem_axi_awready = 0;
        mem_axi_wready  = 0; mem_axi_bvalid = 0; mem_axi_rdata   = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mem_axi_arready = 0; mem_axi_rvalid = 0; mem_axi_awready = 0;
                mem_axi_wready  = 0; mem_axi_bvalid = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                {s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid} = '0;
                {s_awready, s_wvalid, s_wready, s_bvalid, s_bready} = '0;
            end else begin
                ar_hs = s_arvalid && s_arready;
                r_hs  = s_rvalid && s_rready;
                aw_hs = s_awvalid && s_awready;
                w_hs  = s_wvalid && s_wready;
                b_hs  = s_bvalid && s_bready;
                if (ar_hs) begin cap_araddr = s_araddr; cap_arprot = s_arprot; r_pend = 1; r_cnt = 0; end
                if (aw_hs) begin cap_awaddr = s_awaddr; cap_awprot = s_awprot; aw_got = 1; end
                if (w_hs)  begin cap_wdata = s_wdata; cap_wstrb = s_wstrb; w_got = 1; end
                if ((aw_hs || w_hs) && aw_got && w_got) begin
                    resp_mem[cap_awaddr >> 2] = merge(resp_read(cap_awaddr), cap_wdata, cap_wstrb);
                    b_pend = 1; b_cnt = 0;
                end
                if (b_hs) begin aw_got = 0; w_got = 0; end

                // Protocol monitor: valids held with stable payload until accepted, dropped after.
                if (s_arvalid && !s_arready && resp_err !== 1'b1) begin
                    n_vec++;
                    if (mem_axi_arvalid !== 1'b1 || mem_axi_araddr !== s_araddr) begin
                        n_err++;
                        $display("FAIL ar_hold: arvalid=%b araddr=%h, need 1 and %h", mem_axi_arvalid, mem_axi_araddr, s_araddr);
                    end
                end
                if (s_awvalid && !s_awready && resp_err !== 1'b1) begin
                    n_vec++;
                    if (mem_axi_awvalid !== 1'b1 || mem_axi_awaddr !== s_awaddr) begin
                        n_err++;
                        $display("FAIL aw_hold: awvalid=%b awaddr=%h, need 1 and %h", mem_axi_awvalid, mem_axi_awaddr, s_awaddr);
                    end
                end
                if (s_wvalid && !s_wready && resp_err !== 1'b1) begin
                    n_vec++;
                    if (mem_axi_wvalid !== 1'b1 || mem_axi_wdata !== s_wdata || mem_axi_wstrb !== s_wstrb) begin
                        n_err++;
                        $display("FAIL w_hold: wvalid=%b wdata=%h wstrb=%b, need 1 %h %b", mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb, s_wdata, s_wstrb);
                    end
                end
                if (ar_hs || aw_hs || w_hs || r_hs || b_hs) begin
                    n_vec++;
                    if ((ar_hs && mem_axi_arvalid !== 1'b0) || (aw_hs && mem_axi_awvalid !== 1'b0) ||
                        (w_hs && mem_axi_wvalid !== 1'b0) || (r_hs && mem_axi_rready !== 1'b0) ||
                        (b_hs && mem_axi_bready !== 1'b0)) begin
                        n_err++;
                        $display("FAIL drop_after_hs: ar/aw/w/r/b=%b%b%b%b%b, need 0 on handshaken channels",
                                 mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid, mem_axi_rready, mem_axi_bready);
                    end
                end
                if (mem_axi_bready === 1'b1) begin
                    n_vec++;
                    if (!(aw_got && w_got)) begin
                        n_err++;
                        $display("FAIL bready_early: bready=1 with aw_done=%b w_done=%b, need both 1", aw_got, w_got);
                    end
                end

                if (ar_hs) begin mem_axi_arready = 0; ar_cnt = 0; end
                else if (mem_axi_arvalid && !mem_axi_arready) begin
                    if (ar_cnt >= ar_dly) mem_axi_arready = 1; else ar_cnt++;
                end
                if (aw_hs) begin mem_axi_awready = 0; aw_cnt = 0; end
                else if (mem_axi_awvalid && !mem_axi_awready) begin
                    if (aw_cnt >= aw_dly) mem_axi_awready = 1; else aw_cnt++;
                end
                if (w_hs) begin mem_axi_wready = 0; w_cnt = 0; end
                else if (mem_axi_wvalid && !mem_axi_wready) begin
                    if (w_cnt >= w_dly) mem_axi_wready = 1; else w_cnt++;
                end
                if (r_hs) begin mem_axi_rvalid = 0; mem_axi_rdata = $urandom; end
                else if (r_pend) begin
                    if (r_cnt >= r_dly) begin mem_axi_rvalid = 1; mem_axi_rdata = resp_read(cap_araddr); r_pend = 0; end
                    else r_cnt++;
                end
                if (b_hs) mem_axi_bvalid = 0;
                else if (b_pend) begin
                    if (b_cnt >= b_dly) begin mem_axi_bvalid = 1; b_pend = 0; end
                    else b_cnt++;
                end

                s_arvalid = mem_axi_arvalid; s_arready = mem_axi_arready; s_araddr = mem_axi_araddr;
                s_arprot  = mem_axi_arprot;  s_rvalid  = mem_axi_rvalid;  s_rready = mem_axi_rready;
                s_awvalid = mem_axi_awvalid; s_awready = mem_axi_awready; s_awaddr = mem_axi_awaddr;
                s_awprot  = mem_axi_awprot;  s_wvalid  = mem_axi_wvalid;  s_wready = mem_axi_wready;
                s_wdata   = mem_axi_wdata;   s_wstrb   = mem_axi_wstrb;
                s_bvalid  = mem_axi_bvalid;  s_bready  = mem_axi_bready;
            end
        end
    end

    task automatic set_word(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a >> 2]  = d;
        resp_mem[a >> 2] = d;
    endtask

    task automatic recover();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input bit we, input bit insn, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        req_valid = 1; req_we = we; req_insn = insn;
        req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        @(negedge clk);
        req_valid = 0;
        req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom); req_insn = 1'($urandom);
    endtask

    // One complete transaction; d_a = AR/AW delay, d_d = R/W delay, d_b = B delay.
    task automatic run_txn(input bit we, input bit insn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int d_a, input int d_d, input int d_b,
                           input int hold, input bit probe);
        int          lat, exp_lat;
        logic [31:0] exp_rdata;
        @(negedge clk);
        ar_dly = d_a; aw_dly = d_a; r_dly = d_d; w_dly = d_d; b_dly = d_b;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        exp_lat   = we ? 3 + ((d_a > d_d) ? d_a : d_d) + d_b : 3 + d_a + d_d;
        exp_rdata = we ? 32'h0 : ref_read(addr);
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL req_ready_idle: got %b need 1", req_ready); end
        issue(we, insn, addr, wdata, wstrb);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        n_vec++;
        if (resp_valid !== 1'b1) begin
            n_err++; $display("FAIL resp_timeout: no resp_valid after %0d cycles", lat);
            recover();
            return;
        end
        n_vec++;
        if (lat != exp_lat) begin n_err++; $display("FAIL latency: got %0d cycles need %0d", lat, exp_lat); end
        n_vec++;
        if (resp_rdata !== exp_rdata || resp_err !== 1'b0) begin
            n_err++; $display("FAIL resp_data: rdata=%h err=%b need %h 0", resp_rdata, resp_err, exp_rdata);
        end
        n_vec++;
        if (we ? (cap_awaddr !== addr || cap_awprot !== 3'b000 || cap_wdata !== wdata || cap_wstrb !== wstrb)
               : (cap_araddr !== addr || cap_arprot !== {insn, 2'b00})) begin
            n_err++;
            $display("FAIL axi_fields: ar=%h/%b aw=%h/%b w=%h/%b, need addr %h insn %b wdata %h wstrb %b",
                     cap_araddr, cap_arprot, cap_awaddr, cap_awprot, cap_wdata, cap_wstrb, addr, insn, wdata, wstrb);
        end
        for (int h = 0; h < hold; h++) begin
            if (probe) begin req_valid = 1; req_we = 1'($urandom); end
            n_vec++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || req_ready !== 1'b0 ||
                (mem_axi_arvalid | mem_axi_awvalid) !== 1'b0) begin
                n_err++;
                $display("FAIL resp_hold: valid=%b rdata=%h req_ready=%b ar/aw=%b%b, need 1 %h 0 00",
                         resp_valid, resp_rdata, req_ready, mem_axi_arvalid, mem_axi_awvalid, exp_rdata);
            end
            @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0; req_valid = 0;
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_err !== 1'b0) begin
            n_err++; $display("FAIL resp_release: valid=%b req_ready=%b err=%b need 0 1 0", resp_valid, req_ready, resp_err);
        end
        if (we) ref_mem[addr >> 2] = merge(ref_read(addr), wdata, wstrb);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_rready, resp_valid, resp_err} !== 7'b0 ||
            resp_rdata !== 32'h0 || mem_axi_araddr !== 32'h0 || mem_axi_wdata !== 32'h0 || mem_axi_wstrb !== 4'h0 ||
            req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: valids=%b rdata=%h addr=%h wdata=%h wstrb=%b req_ready=%b, need zeros and req_ready 1",
                     {mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_rready, resp_valid, resp_err},
                     resp_rdata, mem_axi_araddr, mem_axi_wdata, mem_axi_wstrb, req_ready);
        end
        rst_n = 1;
    endtask

    task automatic test_read_basic();
        set_word(32'h0000_0100, 32'hDEAD_BEEF);
        run_txn(0, 0, 32'h0000_0100, 32'h0, 4'h0, 2, 3, 0, 0, 0);
    endtask

    task automatic test_write_split();
        run_txn(1, 0, 32'h0000_0040, 32'h1234_5678, 4'b0011, 3, 0, 1, 1, 0);
        run_txn(0, 0, 32'h0000_0040, 32'h0, 4'h0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_fetch();
        run_txn(0, 1, 32'h0000_2000, 32'h0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_txn(0, 0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 5, 1);
        run_txn(1, 0, 32'h0000_0104, 32'hCAFE_F00D, 4'b1111, 0, 0, 0, 5, 1);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        ar_dly = 0; r_dly = 1000; ar_cnt = 0;
        issue(0, 0, 32'h0000_1000, 32'h0, 4'h0);
        n = 0;
        while (mem_axi_rready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_vec++;
        if (mem_axi_rready !== 1'b1) begin n_err++; $display("FAIL reach_r: rready=%b need 1", mem_axi_rready); end
        #2 rst_n = 0;
        #1;
        n_vec++;
        if ({mem_axi_rready, mem_axi_arvalid, resp_valid} !== 3'b000 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async: rready/arvalid/resp_valid=%b req_ready=%b need 000 1",
                     {mem_axi_rready, mem_axi_arvalid, resp_valid}, req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_axi_arvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_release: req_ready=%b resp_valid=%b arvalid=%b need 1 0 0", req_ready, resp_valid, mem_axi_arvalid);
        end
        run_txn(0, 0, 32'h0000_1000, 32'h0, 4'h0, 1, 0, 0, 0, 0);
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        @(negedge clk);
        ar_dly = 100000; ar_cnt = 0;
        issue(0, 0, 32'h0000_1004, 32'h0, 4'h0);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        n_vec++;
        if (lat != TO_CYCLES + 1 || resp_valid !== 1'b1) begin
            n_err++; $display("FAIL timeout_latency: got %0d cycles valid=%b need %0d 1", lat, resp_valid, TO_CYCLES + 1);
        end
        n_vec++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'h0 || mem_axi_arvalid !== 1'b0 || mem_axi_rready !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_resp: err=%b rdata=%h arvalid=%b rready=%b need 1 0 0 0",
                     resp_err, resp_rdata, mem_axi_arvalid, mem_axi_rready);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        n_vec++;
        if (resp_err !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL timeout_clear: err=%b valid=%b req_ready=%b need 0 0 1", resp_err, resp_valid, req_ready);
        end
    endtask
`else
    task automatic test_timeout();
        // Without the watchdog a slow responder simply completes late with no error.
        run_txn(0, 0, 32'h0000_1004, 32'h0, 4'h0, TO_CYCLES + 14, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), 1'($urandom), 32'h0000_1000 + {27'($urandom_range(0, 7)), 2'b00}, $urandom,
                    4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), 1'($urandom));
        end
    endtask

    initial begin
        req_valid = 0; req_we = 0; req_insn = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 0;
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        test_reset();
        test_read_basic();
        test_write_split();
        test_fetch();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "bench watchdog expired");
    end

endmodule
